// File: rtl/cpu_pkg.sv
// Shared definitions for the small accumulator CPU and its program loader:
// memory geometry, opcode encodings, loader FSM states and loader error codes.
package cpu_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;

  // Opcodes occupy the top 3 bits of each instruction byte.
  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    RUN,
    DONE,
    ERR
  } ld_state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_CKSUM = 2'b10;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams a byte image into the CPU memory from address 0
// while holding the CPU in reset, reads it back against an 8-bit checksum,
// then releases the CPU and counts cycles until it halts.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse, begins a load from IDLE/DONE/ERR
//   in_valid/in_data/in_last/in_ready   byte stream, valid/ready handshake
//   mem_addr/mem_wdata/mem_wr/mem_rd    memory port, owned while busy=1
//   mem_rdata           combinational read data
//   cpu_halt            CPU halt flag
//   cpu_rst             active-high CPU reset
//   busy/done/error/err_code            status
//   run_cycles          saturating count of cycles spent running the CPU
module prog_loader #(
  parameter int unsigned AW    = cpu_pkg::AW,
  parameter int unsigned DW    = cpu_pkg::DW,
  parameter int unsigned DEPTH = cpu_pkg::DEPTH,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  input  logic          cpu_halt,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [CW-1:0] run_cycles
);

  import cpu_pkg::*;

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_TOP = AW'(DEPTH - 1);

  ld_state_t     state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [AW:0]   count, count_n;   // one bit wider: a full image is DEPTH bytes
  logic [DW-1:0] wsum, wsum_n;
  logic [DW-1:0] rsum, rsum_n;
  logic [CW-1:0] run_q, run_n;
  logic [1:0]    code_q, code_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr   <= '0;
      count  <= '0;
      wsum   <= '0;
      rsum   <= '0;
      run_q  <= '0;
      code_q <= ERR_NONE;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      count  <= count_n;
      wsum   <= wsum_n;
      rsum   <= rsum_n;
      run_q  <= run_n;
      code_q <= code_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    count_n   = count;
    wsum_n    = wsum;
    rsum_n    = rsum;
    run_n     = run_q;
    code_n    = code_q;
    in_ready  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    cpu_rst   = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;

    case (state)
      IDLE, DONE, ERR: begin
        done    = (state == DONE);
        error   = (state == ERR);
        // The halted CPU is kept out of reset in DONE so it can be inspected.
        cpu_rst = (state != DONE);
        if (start) begin
          state_n = LOAD;
          addr_n  = '0;
          wsum_n  = '0;
          rsum_n  = '0;
          run_n   = '0;
          code_n  = ERR_NONE;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          mem_wr    = 1'b1;
          mem_addr  = addr;
          mem_wdata = in_data;
          wsum_n    = wsum + in_data;
          if (in_last) begin
            count_n = {1'b0, addr} + CNT_ONE;
            addr_n  = '0;
            state_n = VERIFY;
          end else if (addr == ADDR_TOP) begin
            addr_n  = '0;
            code_n  = ERR_OVF;
            state_n = ERR;
          end else begin
            addr_n = addr + 1'b1;
          end
        end
      end

      VERIFY: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = addr;
        rsum_n   = rsum + mem_rdata;
        addr_n   = addr + 1'b1;
        // Decide on the final read using the sum that includes this byte.
        if (({1'b0, addr} + CNT_ONE) == count) begin
          addr_n = '0;
          if (rsum_n == wsum) begin
            state_n = RUN;
          end else begin
            code_n  = ERR_CKSUM;
            state_n = ERR;
          end
        end
      end

      RUN: begin
        cpu_rst = 1'b0;
        if (cpu_halt) begin
          state_n = DONE;
        end else if (run_q != '1) begin
          run_n = run_q + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign err_code   = code_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a memory with optional readback fault and
// a tiny behavioural accumulator CPU sit around the loader.
module tb_prog_loader;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        cpu_halt;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] run_cycles;

  prog_loader #(.AW(5), .DW(8), .DEPTH(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .cpu_halt(cpu_halt), .cpu_rst(cpu_rst),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Memory plus CPU environment
  logic [7:0] mem [32];
  logic       fault = 1'b0;
  logic [4:0] pc;
  logic [7:0] acc;
  logic       halt;
  logic [7:0] ins;
  logic [7:0] opv;

  assign mem_rdata = mem[mem_addr] ^ ((fault && mem_addr == 5'd3) ? 8'h01 : 8'h00);
  assign cpu_halt  = halt;
  assign ins       = mem[pc];
  assign opv       = mem[ins[4:0]];

  always @(posedge clk) begin
    if (busy && mem_wr) mem[mem_addr] <= mem_wdata;
    if (cpu_rst) begin
      pc   <= 5'd0;
      acc  <= 8'h00;
      halt <= 1'b0;
    end else if (!halt && !busy) begin
      pc <= pc + 5'd1;
      case (ins[7:5])
        HLT: begin halt <= 1'b1; pc <= pc; end
        SKZ: pc <= pc + ((acc == 8'h00) ? 5'd2 : 5'd1);
        ADD: acc <= acc + opv;
        AND: acc <= acc & opv;
        XOR: acc <= acc ^ opv;
        LDA: acc <= opv;
        STO: mem[ins[4:0]] <= acc;
        JMP: pc <= ins[4:0];
        default: ;
      endcase
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [3:0] rq[$];   // {done, error, err_code}
  int         checks = 0;
  int         errors = 0;
  int         wr_seen = 0;
  int         rd_seen = 0;
  logic       fin_prev = 1'b0;
  wr_t        e_wr;
  logic [3:0] e_res;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  always @(negedge clk) begin
    if (mem_wr) begin
      wr_seen <= wr_seen + 1;
      if (wq.size() == 0) begin
        fail("unexpected_write");
      end else begin
        e_wr = wq.pop_front();
        check("wr_addr", {27'd0, mem_addr}, {27'd0, e_wr.a});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, e_wr.d});
      end
    end
    if (mem_rd) rd_seen <= rd_seen + 1;
    if ((done || error) && !fin_prev) begin
      if (rq.size() == 0) begin
        fail("unexpected_finish");
      end else begin
        e_res = rq.pop_front();
        check("finish_status", {28'd0, done, error, err_code}, {28'd0, e_res});
      end
    end
    fin_prev <= done || error;
  end

  // Stimulus
  logic [7:0] img [8] = '{8'hA5, 8'h46, 8'hC7, 8'h00, 8'h00, 8'h0A, 8'h05, 8'h00};
  int         w0, r0;
  logic [15:0] rc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic [4:0] a);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    wq.push_back(wr_t'{a: a, d: d});
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail("in_ready_timeout");
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_image(input bit bp);
    for (int i = 0; i < 8; i++) begin
      send(img[i], (i == 7), 5'(i));
      if (bp && i != 7) tick();
    end
  endtask

  task automatic wait_fin();
    int n;
    n = 0;
    while (!(done || error) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) fail("finish_timeout");
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    rst = 1'b1;
    tick();

    // Normal load
    pulse_start();
    w0 = wr_seen; r0 = rd_seen;
    rq.push_back(4'b1000);
    load_image(1'b0);
    wait_fin();
    check("norm_writes", wr_seen - w0, 32'd8);
    check("norm_reads", rd_seen - r0, 32'd8);
    check("norm_mem7", {24'd0, mem[7]}, 32'h0F);
    check("norm_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("norm_run_nonzero", {31'd0, run_cycles != 16'd0}, 32'd1);
    rc = run_cycles;
    repeat (5) @(negedge clk);
    check("norm_run_stable", {16'd0, run_cycles}, {16'd0, rc});

    // start in DONE restarts
    tick();
    pulse_start();
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_in_ready", {31'd0, in_ready}, 32'd1);
    check("restart_run_cycles", {16'd0, run_cycles}, 32'd0);
    check("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);

    // Backpressure, with start pulses in VERIFY and RUN
    w0 = wr_seen; r0 = rd_seen;
    rq.push_back(4'b1000);
    load_image(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_verify", {30'd0, busy, in_ready}, 32'b10);
    begin
      int n;
      n = 0;
      while (cpu_rst && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (cpu_rst) fail("run_timeout");
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run", {30'd0, busy, cpu_rst}, 32'b00);
    wait_fin();
    check("bp_writes", wr_seen - w0, 32'd8);
    check("bp_reads", rd_seen - r0, 32'd8);
    for (int i = 0; i < 7; i++) check("bp_mem", {24'd0, mem[i]}, {24'd0, img[i]});
    check("bp_mem7", {24'd0, mem[7]}, 32'h0F);

    // Overflow
    tick();
    pulse_start();
    w0 = wr_seen; r0 = rd_seen;
    rq.push_back(4'b0101);
    for (int i = 0; i < 32; i++) send(8'h11, 1'b0, 5'(i));
    wait_fin();
    check("ovf_writes", wr_seen - w0, 32'd32);
    check("ovf_reads", rd_seen - r0, 32'd0);
    check("ovf_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("ovf_err_code", {30'd0, err_code}, 32'd1);

    // Checksum fault on readback of address 3
    tick();
    fault = 1'b1;
    pulse_start();
    r0 = rd_seen;
    rq.push_back(4'b0110);
    load_image(1'b0);
    wait_fin();
    check("ck_reads", rd_seen - r0, 32'd8);
    check("ck_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("ck_err_code", {30'd0, err_code}, 32'd2);
    fault = 1'b0;

    // Reset in the middle of LOAD
    tick();
    pulse_start();
    for (int i = 0; i < 3; i++) send(img[i], 1'b0, 5'(i));
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_err", {29'd0, error, err_code}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    pulse_start();
    rq.push_back(4'b1000);
    load_image(1'b0);
    wait_fin();
    check("reload_mem7", {24'd0, mem[7]}, 32'h0F);

    repeat (2) @(negedge clk);
    check("wq_empty", wq.size(), 32'd0);
    check("rq_empty", rq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
